// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, instruction opcode/func values, operand-B select and issue FSM states.
// The decoded-control struct carries an illegal flag only when ILLEGAL_TRAP_EN is defined.
package alu_pkg;

    localparam logic [5:0] ALU_ADD   = 6'd0;
    localparam logic [5:0] ALU_SUB   = 6'd1;
    localparam logic [5:0] ALU_AND   = 6'd2;
    localparam logic [5:0] ALU_OR    = 6'd3;
    localparam logic [5:0] ALU_NOT   = 6'd4;
    localparam logic [5:0] ALU_TCP   = 6'd5;
    localparam logic [5:0] ALU_SHL   = 6'd6;
    localparam logic [5:0] ALU_SHR   = 6'd7;
    localparam logic [5:0] ALU_LHI   = 6'd8;
    localparam logic [5:0] ALU_BNE   = 6'd9;
    localparam logic [5:0] ALU_BEQ   = 6'd10;
    localparam logic [5:0] ALU_BGZ   = 6'd11;
    localparam logic [5:0] ALU_BLZ   = 6'd12;
    localparam logic [5:0] ALU_PASSA = 6'd13;
    localparam logic [5:0] ALU_JPASS = 6'd28;
    localparam logic [5:0] ALU_ONE   = 6'd29;

    localparam logic [3:0] OP_BLZ   = 4'd3;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_ORI   = 4'd5;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [3:0] OP_JAL   = 4'd10;
    localparam logic [3:0] OP_RTYPE = 4'd15;

    localparam logic [5:0] FN_SHR = 6'd7;
    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    // Link register written by JRL / JAL.
    localparam logic [1:0] LINK_REG = 2'd2;

    typedef enum logic [1:0] {
        BSEL_RT   = 2'd0,
        BSEL_SEXT = 2'd1,
        BSEL_ZEXT = 2'd2
    } bsel_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    typedef struct packed {
        logic [5:0]  alu_ctrl;
        bsel_e       b_sel;
        logic [15:0] imm;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic [1:0]  rd;
        logic        reg_write;
        logic        is_branch;
        logic        halt;
`ifdef ILLEGAL_TRAP_EN
        logic        illegal;
`endif
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of one instruction word into ALU control fields.
// Unrecognised encodings become a NOP (PASSA, no enables); flagged illegal under ILLEGAL_TRAP_EN.
module alu_decode
    import alu_pkg::*;
(
    input  logic [15:0] inst_i,
    output dec_t        dec_o
);

    logic [3:0] op;
    logic [5:0] fn;

    assign op = inst_i[15:12];
    assign fn = inst_i[5:0];

    always_comb begin
        dec_o          = '0;
        dec_o.alu_ctrl = ALU_PASSA;
        dec_o.rs       = inst_i[11:10];
        dec_o.rt       = inst_i[9:8];
        // I-type instructions write back to rt.
        dec_o.rd       = (op == OP_RTYPE) ? inst_i[7:6] : inst_i[9:8];

        if (op == OP_RTYPE) begin
            if (fn <= FN_SHR) begin
                dec_o.alu_ctrl  = fn;
                dec_o.reg_write = 1'b1;
            end else begin
                case (fn)
                    FN_JPR: dec_o.alu_ctrl = ALU_JPASS;
                    FN_JRL: begin
                        dec_o.alu_ctrl  = ALU_JPASS;
                        dec_o.reg_write = 1'b1;
                        dec_o.rd        = LINK_REG;
                    end
                    FN_WWD: dec_o.alu_ctrl = ALU_PASSA;
                    FN_HLT: begin
                        dec_o.alu_ctrl = ALU_ONE;
                        dec_o.halt     = 1'b1;
                    end
                    default: begin
`ifdef ILLEGAL_TRAP_EN
                        dec_o.illegal = 1'b1;
`endif
                    end
                endcase
            end
        end else if (op <= OP_BLZ) begin
            dec_o.alu_ctrl  = ALU_BNE + {2'b00, op};
            dec_o.is_branch = 1'b1;
        end else begin
            case (op)
                OP_ADI, OP_LWD: begin
                    dec_o.alu_ctrl  = ALU_ADD;
                    dec_o.b_sel     = BSEL_SEXT;
                    dec_o.reg_write = 1'b1;
                end
                OP_ORI: begin
                    dec_o.alu_ctrl  = ALU_OR;
                    dec_o.b_sel     = BSEL_ZEXT;
                    dec_o.reg_write = 1'b1;
                end
                OP_LHI: begin
                    dec_o.alu_ctrl  = ALU_LHI;
                    dec_o.b_sel     = BSEL_ZEXT;
                    dec_o.reg_write = 1'b1;
                end
                OP_SWD: begin
                    dec_o.alu_ctrl = ALU_ADD;
                    dec_o.b_sel    = BSEL_SEXT;
                end
                OP_JMP: dec_o.alu_ctrl = ALU_ONE;
                OP_JAL: begin
                    dec_o.alu_ctrl  = ALU_ONE;
                    dec_o.reg_write = 1'b1;
                    dec_o.rd        = LINK_REG;
                end
                default: begin
`ifdef ILLEGAL_TRAP_EN
                    dec_o.illegal = 1'b1;
`endif
                end
            endcase
        end

        case (dec_o.b_sel)
            BSEL_SEXT: dec_o.imm = {{8{inst_i[7]}}, inst_i[7:0]};
            BSEL_ZEXT: dec_o.imm = {8'h00, inst_i[7:0]};
            default:   dec_o.imm = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage: decodes into a valid/ready output register, with a HLT freeze FSM and issue counter.
// ILLEGAL_TRAP_EN adds out_illegal and makes illegal encodings halt the stage like HLT.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_inst,
    input  logic [15:0]      in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_alu_ctrl,
    output logic [1:0]       out_b_sel,
    output logic [15:0]      out_imm,
    output logic [1:0]       out_rs,
    output logic [1:0]       out_rt,
    output logic [1:0]       out_rd,
    output logic [15:0]      out_pc,
    output logic             out_reg_write,
    output logic             out_is_branch,
    output logic             out_halt,
`ifdef ILLEGAL_TRAP_EN
    output logic             out_illegal,
`endif
    output logic             halted,
    output logic [CNT_W-1:0] issue_count
);

    dec_t             dec, dec_q, dec_d;
    logic             valid_q, valid_d;
    logic [15:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state_q, state_d;
    logic             load, trap;

    alu_decode u_decode (
        .inst_i (in_inst),
        .dec_o  (dec)
    );

    assign in_ready = (state_q == ST_RUN) && (!valid_q || out_ready);
    assign load     = in_valid && in_ready;
`ifdef ILLEGAL_TRAP_EN
    assign trap     = dec.halt || dec.illegal;
`else
    assign trap     = dec.halt;
`endif

    always_comb begin
        valid_d = valid_q;
        dec_d   = dec_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (valid_q && out_ready && !flush)
            cnt_d = cnt_q + CNT_W'(1);
        // Flush wins over a same-cycle load; the register contents are left as-is.
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            dec_d   = dec;
            pc_d    = in_pc;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (load && !flush && trap) state_d = ST_HALTED;
            // Only a flush of the still-held halting instruction resumes issue.
            ST_HALTED: if (flush && valid_q)       state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            dec_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
            state_q <= ST_RUN;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_alu_ctrl  = dec_q.alu_ctrl;
    assign out_b_sel     = dec_q.b_sel;
    assign out_imm       = dec_q.imm;
    assign out_rs        = dec_q.rs;
    assign out_rt        = dec_q.rt;
    assign out_rd        = dec_q.rd;
    assign out_pc        = pc_q;
    assign out_reg_write = dec_q.reg_write;
    assign out_is_branch = dec_q.is_branch;
    assign out_halt      = dec_q.halt;
`ifdef ILLEGAL_TRAP_EN
    assign out_illegal   = dec_q.illegal;
`endif
    assign halted        = (state_q == ST_HALTED);
    assign issue_count   = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed + random bench for alu_issue_stage against a cycle-level reference model.
// Honors ILLEGAL_TRAP_EN the same way as the design.
module tb_alu_issue_stage;

    localparam int CW = 4;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk, reset_n, in_valid, flush, out_ready;
    logic [15:0]   in_inst, in_pc;
    logic          in_ready, out_valid, out_reg_write, out_is_branch, out_halt, halted;
    logic [5:0]    out_alu_ctrl;
    logic [1:0]    out_b_sel, out_rs, out_rt, out_rd;
    logic [15:0]   out_imm, out_pc;
    logic [CW-1:0] issue_count;
`ifdef ILLEGAL_TRAP_EN
    logic          out_illegal;
`endif

    alu_issue_stage #(.CNT_W(CW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_alu_ctrl  (out_alu_ctrl),
        .out_b_sel     (out_b_sel),
        .out_imm       (out_imm),
        .out_rs        (out_rs),
        .out_rt        (out_rt),
        .out_rd        (out_rd),
        .out_pc        (out_pc),
        .out_reg_write (out_reg_write),
        .out_is_branch (out_is_branch),
        .out_halt      (out_halt),
`ifdef ILLEGAL_TRAP_EN
        .out_illegal   (out_illegal),
`endif
        .halted        (halted),
        .issue_count   (issue_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [5:0]  ctrl;
        logic [1:0]  bsel;
        logic [15:0] imm;
        logic [1:0]  rs, rt, rd;
        logic        rw, br, h, ill;
    } exp_t;

    // Reference state: what the stage should be holding after each edge.
    logic          m_valid, m_halted;
    logic [CW-1:0] m_cnt;
    logic [15:0]   m_pc;
    exp_t          m_f;
    int            n_cmp = 0, n_bad = 0;

    function automatic exp_t ref_dec(input logic [15:0] i);
        exp_t e;
        int   op, fn;
        op = int'(i[15:12]);
        fn = int'(i[5:0]);
        e = '0;
        e.ctrl = 6'd13;
        e.rs = i[11:10];
        e.rt = i[9:8];
        e.rd = (op == 15) ? i[7:6] : i[9:8];
        if (op == 15) begin
            if (fn <= 7) begin e.ctrl = 6'(fn); e.rw = 1'b1; end
            else if (fn == 25) e.ctrl = 6'd28;
            else if (fn == 26) begin e.ctrl = 6'd28; e.rw = 1'b1; e.rd = 2'd2; end
            else if (fn == 28) e.ctrl = 6'd13;
            else if (fn == 29) begin e.ctrl = 6'd29; e.h = 1'b1; end
            else e.ill = 1'b1;
        end else if (op <= 3) begin
            e.ctrl = 6'(9 + op);
            e.br = 1'b1;
        end else begin
            case (op)
                4:  begin e.ctrl = 6'd0; e.bsel = 2'd1; e.rw = 1'b1; end
                5:  begin e.ctrl = 6'd3; e.bsel = 2'd2; e.rw = 1'b1; end
                6:  begin e.ctrl = 6'd8; e.bsel = 2'd2; e.rw = 1'b1; end
                7:  begin e.ctrl = 6'd0; e.bsel = 2'd1; e.rw = 1'b1; end
                8:  begin e.ctrl = 6'd0; e.bsel = 2'd1; end
                9:  e.ctrl = 6'd29;
                10: begin e.ctrl = 6'd29; e.rw = 1'b1; e.rd = 2'd2; end
                default: e.ill = 1'b1;
            endcase
        end
        if (e.bsel == 2'd1)
            e.imm = i[7] ? (16'hFF00 | {8'h00, i[7:0]}) : {8'h00, i[7:0]};
        else if (e.bsel == 2'd2)
            e.imm = {8'h00, i[7:0]};
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("halted", 32'(halted), 32'(m_halted));
        check("issue_count", 32'(issue_count), 32'(m_cnt));
        if (m_valid) begin
            check("alu_ctrl", 32'(out_alu_ctrl), 32'(m_f.ctrl));
            check("b_sel", 32'(out_b_sel), 32'(m_f.bsel));
            check("imm", 32'(out_imm), 32'(m_f.imm));
            check("rs", 32'(out_rs), 32'(m_f.rs));
            check("rt", 32'(out_rt), 32'(m_f.rt));
            check("rd", 32'(out_rd), 32'(m_f.rd));
            check("pc", 32'(out_pc), 32'(m_pc));
            check("reg_write", 32'(out_reg_write), 32'(m_f.rw));
            check("is_branch", 32'(out_is_branch), 32'(m_f.br));
            check("halt", 32'(out_halt), 32'(m_f.h));
`ifdef ILLEGAL_TRAP_EN
            check("illegal", 32'(out_illegal), 32'(m_f.ill));
`endif
        end
    endtask

    // Called at posedge+1; asserts reset between edges so the clear is seen asynchronously.
    task automatic do_reset();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        reset_n = 1'b0;
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_count", 32'(issue_count), 32'd0);
        check("rst_fields", {out_alu_ctrl, out_b_sel, out_rs, out_rt, out_rd,
                             out_reg_write, out_is_branch, out_halt}, 32'd0);
        check("rst_imm_pc", {out_imm, out_pc}, 32'd0);
        reset_n = 1'b1;
        m_valid = 1'b0; m_halted = 1'b0; m_cnt = '0; m_pc = '0; m_f = '0;
        @(posedge clk); #1;
        chk_all();
    endtask

    // One clock: drive inputs, check in_ready, advance the model, check registered outputs.
    task automatic cyc(input logic v, input logic [15:0] i, input logic [15:0] p,
                       input logic f, input logic r);
        exp_t d;
        logic rdy, ld;
        in_valid = v; in_inst = i; in_pc = p; flush = f; out_ready = r;
        #1;
        rdy = !m_halted && (!m_valid || r);
        check("in_ready", 32'(in_ready), 32'(rdy));
        ld = v && rdy;
        d  = ref_dec(i);
        @(posedge clk); #1;
        if (m_valid && r && !f) m_cnt = m_cnt + 1'b1;
        if (f && m_valid && m_halted) m_halted = 1'b0;
        else if (ld && !f && (d.h || (TRAP && d.ill))) m_halted = 1'b1;
        if (f) m_valid = 1'b0;
        else if (ld) begin m_valid = 1'b1; m_f = d; m_pc = p; end
        else if (r) m_valid = 1'b0;
        chk_all();
    endtask

    function automatic logic [15:0] rnd_inst();
        int          r;
        logic [15:0] x;
        x = 16'($urandom);
        r = $urandom_range(0, 19);
        if (r == 0) x = 16'hF01D | (x & 16'h0FC0);
        else if (r < 10) begin
            x[15:12] = 4'hF;
            case ($urandom_range(0, 4))
                0: x[5:0] = 6'd25;
                1: x[5:0] = 6'd26;
                2: x[5:0] = 6'd28;
                3: x[5:0] = 6'($urandom_range(0, 7));
                default: if (x[5:0] == 6'd29) x[5:0] = 6'd30;
            endcase
        end else x[15:12] = 4'($urandom_range(0, 14));
        return x;
    endfunction

    initial begin
        logic [15:0] ri;
        in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        do_reset();

        cyc(1'b1, 16'hF0C0, 16'h0100, 1'b0, 1'b1);
        check("add_ctrl", 32'(out_alu_ctrl), 32'd0);
        check("add_rw", 32'(out_reg_write), 32'd1);
        check("add_cnt", 32'(issue_count), 32'd0);
        cyc(1'b1, 16'h41FE, 16'h0102, 1'b0, 1'b1);
        check("adi_imm", 32'(out_imm), 32'hFFFE);
        check("adi_rd", 32'(out_rd), 32'd1);
        check("add_cnt1", 32'(issue_count), 32'd1);
        cyc(1'b1, 16'h51FE, 16'h0104, 1'b0, 1'b1);
        check("ori_bsel", 32'(out_b_sel), 32'd2);
        check("ori_imm", 32'(out_imm), 32'h00FE);

        repeat (3) cyc(1'b1, 16'hF0C1, 16'h0106, 1'b0, 1'b0);
        check("stall_ready", 32'(in_ready), 32'd0);
        check("stall_hold", 32'(out_alu_ctrl), 32'd3);
        check("stall_cnt", 32'(issue_count), 32'd2);
        cyc(1'b1, 16'hF0C1, 16'h0106, 1'b0, 1'b1);
        check("sub_ctrl", 32'(out_alu_ctrl), 32'd1);

        cyc(1'b1, 16'h1600, 16'h0108, 1'b0, 1'b1);
        check("beq_ctrl", 32'(out_alu_ctrl), 32'd10);
        check("beq_br", 32'(out_is_branch), 32'd1);
        cyc(1'b1, 16'hF0C1, 16'h010A, 1'b1, 1'b1);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_cnt", 32'(issue_count), 32'd4);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);

        cyc(1'b1, 16'hF01D, 16'h0200, 1'b0, 1'b0);
        check("hlt_halt", 32'(out_halt), 32'd1);
        check("hlt_halted", 32'(halted), 32'd1);
        repeat (10) cyc(1'b1, 16'hF0C0, 16'h0202, 1'b0, 1'b0);
        check("hlt_ready", 32'(in_ready), 32'd0);
        check("hlt_pc", 32'(out_pc), 32'h0200);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check("hlt_drained", 32'(halted), 32'd1);
        do_reset();

        cyc(1'b1, 16'hF01D, 16'h0300, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        check("hlt_flush_run", 32'(halted), 32'd0);
        cyc(1'b1, 16'hF0C0, 16'h0302, 1'b0, 1'b1);

        cyc(1'b1, 16'hB000, 16'h0400, 1'b0, 1'b1);
        check("illegal_nop", 32'(out_alu_ctrl), 32'd13);
        check("illegal_rw", 32'(out_reg_write), 32'd0);
`ifdef ILLEGAL_TRAP_EN
        check("illegal_flag", 32'(out_illegal), 32'd1);
        check("illegal_halt", 32'(halted), 32'd1);
`endif
        do_reset();

        cyc(1'b1, 16'hF0C0, 16'h0500, 1'b0, 1'b0);
        do_reset();

        for (int n = 0; n < 600; n++) begin
            if (m_halted && !m_valid) begin
                do_reset();
            end else begin
                ri = rnd_inst();
                cyc($urandom_range(0, 3) != 0, ri, 16'($urandom),
                    ($urandom_range(0, 15) == 0) || (m_halted && $urandom_range(0, 3) == 0),
                    $urandom_range(0, 3) != 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
